group_serial_subtractor: RTL and testbench

Multi-cycle two's-complement subtractor computing D = A − B − bin one GROUPSIZE-bit slice per clock, with a borrow register chained between slices. It is the subtraction counterpart of the group-structured parallel-prefix adder and shares its operand width and group size. It is intended for ALU paths that accept extra latency in exchange for area. Operands enter and results leave through valid/ready handshakes.

---
 rtl/group_serial_subtractor_if.sv | 25 ++
 rtl/group_serial_subtractor.sv | 105 ++++++++++
 tb/tb_group_serial_subtractor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/group_serial_subtractor_if.sv
// Valid/ready operand and result channels of the group-serial subtractor.
interface group_serial_subtractor_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );
endinterface

// File: rtl/group_serial_subtractor.sv
// D = A - B - bin computed one GROUP-bit slice per clock, borrow chained
// through a register; operands and result move over valid/ready handshakes.
module group_serial_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 4
) (
    input logic                   clk,
    input logic                   rst,
    group_serial_subtractor_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / GROUP;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] d_r;
    logic             bout_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [GROUP-1:0] a_sl;
    logic [GROUP-1:0] b_sl;
    logic [GROUP-1:0] diff;
    logic             br;
    logic             last;

    // Current slice difference with borrow-in and borrow-out.
    always_comb begin
        a_sl        = a_r[int'(cnt)*GROUP +: GROUP];
        b_sl        = b_r[int'(cnt)*GROUP +: GROUP];
        {br, diff}  = {1'b0, a_sl} - {1'b0, b_sl} - (GROUP+1)'(borrow);
        last        = (cnt == CW'(NSLICE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            borrow      <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            d_r         <= '0;
            bout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        borrow     <= bus.bin;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    d_r[int'(cnt)*GROUP +: GROUP] <= diff;
                    borrow <= br;
                    if (last) begin
                        // Final slice carries the sign bit, so overflow is settled here.
                        bout_r      <= br;
                        ovf_r       <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) &
                                       (diff[GROUP-1] ^ a_r[WIDTH-1]);
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.d         = d_r;
    assign bus.bout      = bout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_group_serial_subtractor.sv
// Self-checking bench: directed vector table, handshake corner cases and
// random operands against an arithmetic reference model.
module tb_group_serial_subtractor;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned GROUP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    group_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    group_serial_subtractor #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                  output logic [31:0] d, output logic bout, output logic ovf);
        logic [32:0] t;
        t    = {1'b0, a} - {1'b0, b} - 33'(bin);
        d    = t[31:0];
        bout = ({1'b0, a} < ({1'b0, b} + 33'(bin)));
        ovf  = (a[31] != b[31]) && (d[31] != a[31]);
    endfunction

    // Present operands once in_ready is seen, then count edges until out_valid.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                            output int lat);
        int w;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_after_xfer", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_xfer", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic bin, input logic [31:0] ed, input logic eb, input logic eo);
        int lat;
        start_op(a, b, bin, lat);
        check({name, "_latency"}, 32'(lat), 32'd8);
        check({name, "_d"}, bus.d, ed);
        check({name, "_bout"}, 32'(bus.bout), 32'(eb));
        check({name, "_ovf"}, 32'(bus.ovf), 32'(eo));
        finish_op();
    endtask

    initial begin
        logic [31:0] ra, rb, ed, dhold;
        logic        rbin, eb, eo;
        int          lat;

        vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
        vecs[4] = '{32'h00000010, 32'h0000000F, 1'b1, 32'h00000000, 1'b0, 1'b0};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_d", bus.d, 32'd0);
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                   vecs[i].d, vecs[i].bout, vecs[i].ovf);

        // Backpressure with an ignored in_valid pulse during RUN.
        bus.a = 32'h12345678;
        bus.b = 32'h01234567;
        bus.bin = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("bp_in_ready_run", 32'(bus.in_ready), 32'd0);
        bus.a = 32'hDEADBEEF;
        bus.b = 32'h0BADF00D;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 2;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd8);
        dhold = bus.d;
        check("bp_d", dhold, 32'h11111111);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_d", bus.d, 32'h11111111);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        finish_op();
        tick();
        tick();
        check("no_queued_op", 32'(bus.out_valid), 32'd0);
        run_op("after_bp", 32'h00000009, 32'h00000004, 1'b0, 32'h00000005, 1'b0, 1'b0);

        // Asynchronous reset after three RUN cycles.
        bus.a = 32'hFEDCBA98;
        bus.b = 32'h01234567;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_d", bus.d, 32'd0);
        check("mid_rst_bout", 32'(bus.bout), 32'd0);
        check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst = 1'b0;
        tick();
        check("in_ready_after_mid_rst", 32'(bus.in_ready), 32'd1);
        run_op("after_rst", 32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0);

        // Random operands against the reference model.
        for (int n = 0; n < 25; n++) begin
            ra = $urandom;
            rb = $urandom;
            rbin = 1'($urandom_range(0, 1));
            if (n % 5 == 0) rb = ra;
            model(ra, rb, rbin, ed, eb, eo);
            run_op($sformatf("rand%0d", n), ra, rb, rbin, ed, eb, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
